// File: rtl/board_frame_ctrl_if.sv
// board_frame_ctrl_if
//   Cell-write handshake between game logic (master) and the frame
//   controller (slave). A write transfers when wr_valid && wr_ready.
//
//   wr_valid  master->slave  cell write request
//   wr_ready  slave->master  write can be accepted this cycle
//   wr_row    master->slave  cell row, 0 = top (x1)
//   wr_col    master->slave  cell column, 0 = leftmost (bits [11:0])
//   wr_color  master->slave  RGB444 cell colour
interface board_frame_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_row;
  logic [1:0]  wr_col;
  logic [11:0] wr_color;

  modport master (
    output wr_valid,
    output wr_row,
    output wr_col,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_row,
    input  wr_col,
    input  wr_color,
    output wr_ready
  );
endinterface

// File: rtl/board_frame_ctrl.sv
// board_frame_ctrl
//   Sequences updates to the 4x4 cell-colour buffer feeding the VGA grid
//   renderer. Game logic writes cells into a staging buffer; a commit
//   copies staging into the displayed buffer one row per cycle, starting
//   only at the first blanking line of a frame so a frame never tears.
//   Also times the renderer's error border flash in whole frames.
//
// Ports
//   clk             pixel clock, shared with the renderer
//   reset           asynchronous, active-high reset
//   y               current scan line from the VGA sync generator
//   wr              cell-write handshake (slave side)
//   clear_req       pulse: fill staging with CLEAR_COLOR
//   commit_req      pulse: publish staging at the next blanking start
//   error_req       pulse: (re)start the error flash
//   x1..x4          displayed rows 0..3, cell c at [12c+11:12c]
//   commit_pending  high while a commit is waiting or copying
//   commit_done     one-cycle pulse after the last row is published
//   error           border error flag to the renderer
module board_frame_ctrl #(
  parameter int unsigned VBLANK_LINE = 480,
  parameter int unsigned ERR_FRAMES  = 30,
  parameter logic [11:0] RESET_COLOR = 12'h000,
  parameter logic [11:0] CLEAR_COLOR = 12'hCCC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               y,
  board_frame_ctrl_if.slave        wr,
  input  logic                     clear_req,
  input  logic                     commit_req,
  input  logic                     error_req,
  output logic [47:0]              x1,
  output logic [47:0]              x2,
  output logic [47:0]              x3,
  output logic [47:0]              x4,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic                     error
);

  localparam logic [9:0] VBL_Y    = VBLANK_LINE[9:0];
  localparam logic [7:0] ERR_LOAD = ERR_FRAMES[7:0];

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  // Each row is packed so a displayed row drives an x output directly.
  logic [3:0][11:0]  r_stage [0:3];
  logic [3:0][11:0]  r_disp  [0:3];

  logic [1:0]        r_row_idx;
  logic [9:0]        r_y_q;
  logic [7:0]        r_err_cnt;
  logic              r_commit_done;

  logic              w_frame_start;
  logic              w_wr_ready;
  logic              w_wr_accept;
  logic              w_copy_en;
  logic              w_copy_last;
  logic              w_copy_start;

  // --------------------------------------------------------------------
  // Frame boundary: one pulse on the cycle y first equals the blanking
  // line, however long y then dwells there.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= y;
    end
  end

  assign w_frame_start = (y == VBL_Y) && (r_y_q != VBL_Y);

  // --------------------------------------------------------------------
  // Commit state machine
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // frame_start is only looked at from PENDING, so one coinciding with
  // the IDLE->PENDING cycle is naturally skipped.
  always_comb begin
    w_next_state = r_state;
    w_wr_ready   = 1'b0;
    w_copy_en    = 1'b0;
    w_copy_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wr_ready = !clear_req;
        if (commit_req) begin
          w_next_state = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_frame_start) begin
          w_copy_start = 1'b1;
          w_next_state = ST_COPY;
        end
      end
      ST_COPY: begin
        w_copy_en = 1'b1;
        if (r_row_idx == 2'd3) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_copy_last = w_copy_en && (r_row_idx == 2'd3);
  assign w_wr_accept = wr.wr_valid && w_wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_idx     <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_copy_last;
      if (w_copy_start) begin
        r_row_idx <= '0;
      end else if (w_copy_en) begin
        r_row_idx <= r_row_idx + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Staging buffer: only writable in IDLE; clear beats a same-cycle
  // write (which is also refused through wr_ready).
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '{default: {4{RESET_COLOR}}};
    end else if (r_state == ST_IDLE) begin
      if (clear_req) begin
        r_stage <= '{default: {4{CLEAR_COLOR}}};
      end else if (w_wr_accept) begin
        r_stage[wr.wr_row][wr.wr_col] <= wr.wr_color;
      end
    end
  end

  // --------------------------------------------------------------------
  // Displayed buffer: changes only while copying, one row per cycle.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp <= '{default: {4{RESET_COLOR}}};
    end else if (w_copy_en) begin
      r_disp[r_row_idx] <= r_stage[r_row_idx];
    end
  end

  // --------------------------------------------------------------------
  // Error flash timer, counted in frames. A load beats a same-cycle
  // frame_start, so a retrigger always restarts the full duration.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (error_req) begin
      r_err_cnt <= ERR_LOAD;
    end else if (w_frame_start && (r_err_cnt != '0)) begin
      r_err_cnt <= r_err_cnt - 8'd1;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign wr.wr_ready     = w_wr_ready;
  assign x1              = r_disp[0];
  assign x2              = r_disp[1];
  assign x3              = r_disp[2];
  assign x4              = r_disp[3];
  assign commit_pending  = (r_state != ST_IDLE);
  assign commit_done     = r_commit_done;
  assign error           = (r_err_cnt != '0);

  // --------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------
  a_done_in_idle : assert property (@(posedge clk) disable iff (reset)
    r_commit_done |-> (r_state == ST_IDLE));

  a_disp_stable_outside_copy : assert property (@(posedge clk) disable iff (reset)
    (r_state != ST_COPY) |=> $stable(r_disp[r_row_idx]));

  a_no_write_when_busy : assert property (@(posedge clk) disable iff (reset)
    (r_state != ST_IDLE) |-> !w_wr_ready);

endmodule

// File: tb/tb_board_frame_ctrl.sv
module tb_board_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  y;
  logic        clear_req, commit_req, error_req;
  logic [47:0] x1, x2, x3, x4;
  logic        commit_pending, commit_done, error;

  board_frame_ctrl_if bus ();

  board_frame_ctrl #(
    .VBLANK_LINE (480),
    .ERR_FRAMES  (3),
    .RESET_COLOR (12'h000),
    .CLEAR_COLOR (12'hCCC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .y              (y),
    .wr             (bus.slave),
    .clear_req      (clear_req),
    .commit_req     (commit_req),
    .error_req      (error_req),
    .x1             (x1),
    .x2             (x2),
    .x3             (x3),
    .x4             (x4),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .error          (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] RZ  = 48'h000000000000;
  localparam logic [47:0] RC  = 48'hCCCCCCCCCCCC;
  localparam logic [47:0] RF  = 48'hF80000000000;   // cell 3 = F80
  localparam logic [47:0] RA  = 48'hCCCCCCABCCCC;   // cell 1 = ABC

  // Expectations describe the outputs during the cycle the inputs are
  // applied, i.e. before the edge that samples them.
  typedef struct {
    logic [9:0]  y;
    logic        wv;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [11:0] color;
    logic        clr;
    logic        cmt;
    logic        ereq;
    logic        e_ready;
    logic        e_pend;
    logic        e_done;
    logic        e_err;
    logic [47:0] e_x1;
    logic [47:0] e_x2;
    logic [47:0] e_x3;
    logic [47:0] e_x4;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [9:0] yy, input logic wv, input logic [1:0] rw, input logic [1:0] cl,
                              input logic [11:0] co, input logic clr, input logic cmt, input logic er,
                              input logic r, input logic p, input logic d, input logic e,
                              input logic [47:0] a, input logic [47:0] b, input logic [47:0] c, input logic [47:0] dd);
    vec_t v;
    v.y = yy; v.wv = wv; v.row = rw; v.col = cl; v.color = co;
    v.clr = clr; v.cmt = cmt; v.ereq = er;
    v.e_ready = r; v.e_pend = p; v.e_done = d; v.e_err = e;
    v.e_x1 = a; v.e_x2 = b; v.e_x3 = c; v.e_x4 = dd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_row   = 2'd0;
    bus.wr_col   = 2'd0;
    bus.wr_color = 12'h000;
    clear_req    = 1'b0;
    commit_req   = 1'b0;
    error_req    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;

    // --- commit of a single write, y held at 480 through the copy ---
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd0,   1, 2, 3, 12'hF80, 0, 0, 0,  1, 0, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 1, 0,  1, 0, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd479, 1, 0, 0, 12'h123, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RZ, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 1, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 0, RZ, RZ, RF, RZ));
    // --- clear with a same-cycle write, then commit ---
    vecs.push_back(mk(10'd480, 1, 0, 0, 12'h00F, 1, 0, 0,  0, 0, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 1, 0,  1, 0, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RZ, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RZ, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RF, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RZ));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 1, 0, RC, RC, RC, RC));
    // --- commit coinciding with frame_start waits one more frame ---
    vecs.push_back(mk(10'd0,   1, 1, 1, 12'hABC, 0, 0, 0,  1, 0, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 1, 0,  1, 0, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RC, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  0, 1, 0, 0, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 1, 0, RC, RA, RC, RC));
    // --- error flash: 3 frames, retrigger after 2, load beats frame_start ---
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 0, 0, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 0, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 0, 0, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd480, 0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 1, RC, RA, RC, RC));
    vecs.push_back(mk(10'd0,   0, 0, 0, 12'h000, 0, 0, 0,  1, 0, 0, 0, RC, RA, RC, RC));

    // --- reset ---
    idle_inputs();
    y     = 10'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // --- table-driven section ---
    foreach (vecs[i]) begin
      y            = vecs[i].y;
      bus.wr_valid = vecs[i].wv;
      bus.wr_row   = vecs[i].row;
      bus.wr_col   = vecs[i].col;
      bus.wr_color = vecs[i].color;
      clear_req    = vecs[i].clr;
      commit_req   = vecs[i].cmt;
      error_req    = vecs[i].ereq;
      @(negedge clk);
      chk("wr_ready",       i, 48'(bus.wr_ready),   48'(vecs[i].e_ready));
      chk("commit_pending", i, 48'(commit_pending), 48'(vecs[i].e_pend));
      chk("commit_done",    i, 48'(commit_done),    48'(vecs[i].e_done));
      chk("error",          i, 48'(error),          48'(vecs[i].e_err));
      chk("x1",             i, x1, vecs[i].e_x1);
      chk("x2",             i, x2, vecs[i].e_x2);
      chk("x3",             i, x3, vecs[i].e_x3);
      chk("x4",             i, x4, vecs[i].e_x4);
      tick();
    end

    // --- reset in the middle of a copy, error flash active ---
    idle_inputs();
    y            = 10'd0;
    error_req    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_row   = 2'd3;
    bus.wr_col   = 2'd2;
    bus.wr_color = 12'h5A5;
    tick();
    idle_inputs();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();                 // pending, y = 0
    y = 10'd480;
    tick();                 // frame_start sampled -> COPY
    tick();                 // row 0 published
    tick();                 // row 1 published
    @(negedge clk);
    chk("midcopy_pending", 0, 48'(commit_pending), 48'd1);
    chk("midcopy_error",   0, 48'(error),          48'd1);
    reset = 1'b1;
    #1;
    chk("rst_x1",      0, x1, RZ);
    chk("rst_x2",      0, x2, RZ);
    chk("rst_x3",      0, x3, RZ);
    chk("rst_x4",      0, x4, RZ);
    chk("rst_pending", 0, 48'(commit_pending), 48'd0);
    chk("rst_error",   0, 48'(error),          48'd0);
    chk("rst_done",    0, 48'(commit_done),    48'd0);
    chk("rst_ready",   0, 48'(bus.wr_ready),   48'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_pending", 0, 48'(commit_pending), 48'd0);
    chk("post_rst_x4",      0, x4, RZ);

    // Staging was reset too: a fresh commit must publish RESET_COLOR.
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    y = 10'd0;
    tick();
    y = 10'd480;
    tick();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (commit_done) begin
        got = 1;
        break;
      end
    end
    chk("recommit_done_seen", 0, 48'(got), 48'd1);
    chk("recommit_x1",        0, x1, RZ);
    chk("recommit_x2",        0, x2, RZ);
    chk("recommit_x3",        0, x3, RZ);
    chk("recommit_x4",        0, x4, RZ);
    chk("recommit_error",     0, 48'(error), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
